// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_pkg
//  Brief    : Shared widths, state encoding and decode helper for the
//             one-hot pulse decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package onehot_pkg;

    localparam int N_LINES = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic logic [N_LINES-1:0] dec_onehot(
        input logic [IDX_W-1:0] idx,
        input logic             en
    );
        logic [N_LINES-1:0] w_word;
        w_word = '0;
        if (en) begin
            w_word[idx] = 1'b1;
        end
        return w_word;
    endfunction

    // Width able to hold max(h, g); never narrower than one bit.
    function automatic int cnt_width(input int h, input int g);
        int w_max;
        w_max = (h > g) ? h : g;
        return ($clog2(w_max + 1) < 1) ? 1 : $clog2(w_max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_pulse_decoder_dec3to8_comb.sv
`default_nettype none
// ============================================================================
//  Module   : dec3to8_comb
//  Brief    : Purely combinational 3-to-8 decoder with line enable.
//  Revision : 1.0 - initial release
// ============================================================================
module dec3to8_comb
    import onehot_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_en,
    output logic [N_LINES-1:0] o_word
);

    always_comb begin
        o_word = dec_onehot(i_idx, i_en);
    end

endmodule
`default_nettype wire

// File: rtl/onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_pulse_decoder
//  Brief    : Accepts an index via valid/ready and drives the matching
//             one-hot line for HOLD_CYCLES, then GAP_CYCLES of zeros.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_pulse_decoder
    import onehot_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_en,
    output logic [N_LINES-1:0] out_onehot,
    output logic               out_valid,
    output logic               busy
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    localparam logic [1:0]       c_ST_IDLE  = IDLE;
    localparam logic [1:0]       c_ST_HOLD  = HOLD;
    localparam logic [1:0]       c_ST_GAP   = GAP;
    localparam logic [CNT_W-1:0] c_HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("onehot_pulse_decoder: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 0) begin : g_bad_gap
            $error("onehot_pulse_decoder: GAP_CYCLES must be >= 0");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_LINES-1:0] r_onehot;
    logic               r_valid;
    logic [N_LINES-1:0] w_word;
    logic               w_idle;

    dec3to8_comb u_dec (
        .i_idx  (in_idx),
        .i_en   (in_en),
        .o_word (w_word)
    );

    // Ready depends on state alone, so there is no path from in_valid.
    assign w_idle     = (r_state == c_ST_IDLE);
    assign in_ready   = w_idle;
    assign busy       = ~w_idle;
    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_onehot <= w_word;
                        r_valid  <= 1'b1;
                        r_cnt    <= c_HOLD_LD;
                        r_state  <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_onehot <= '0;
                        r_valid  <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_cnt   <= c_GAP_LD;
                            r_state <= c_ST_GAP;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_cnt    <= '0;
                    r_onehot <= '0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_pulse_decoder
//  Brief    : Self-checking bench: default instance plus HOLD=1/GAP=0 corner.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_pulse_decoder;

    localparam int H_A = 4;
    localparam int G_A = 1;
    localparam int H_B = 1;
    localparam int G_B = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_en = 1'b0;
    logic [2:0] in_idx = 3'd0;

    logic       a_ready, a_valid, a_busy;
    logic [7:0] a_onehot;
    logic       b_ready, b_valid, b_busy;
    logic [7:0] b_onehot;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    onehot_pulse_decoder #(.HOLD_CYCLES(H_A), .GAP_CYCLES(G_A)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_idx(in_idx), .in_en(in_en), .out_onehot(a_onehot),
        .out_valid(a_valid), .busy(a_busy)
    );

    onehot_pulse_decoder #(.HOLD_CYCLES(H_B), .GAP_CYCLES(G_B)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_idx(in_idx), .in_en(in_en), .out_onehot(b_onehot),
        .out_valid(b_valid), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: age counts cycles since the accept edge (0 = idle).
    int         age [2]   = '{0, 0};
    logic [7:0] mword [2] = '{8'h00, 8'h00};
    int         midx [2]  = '{0, 0};
    int         hc [2]    = '{H_A, H_B};
    int         gc [2]    = '{G_A, G_B};

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                age[d] = 0;
            end else if (age[d] == 0) begin
                if (in_valid) begin
                    age[d]   = 1;
                    mword[d] = in_en ? 8'(1 << in_idx) : 8'h00;
                    midx[d]  = int'(in_idx);
                end
            end else if (age[d] >= hc[d] + gc[d]) begin
                age[d] = 0;
            end else begin
                age[d]++;
            end
        end
    end

    function automatic int prio_enc(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) return i;
        end
        return -1;
    endfunction

    task automatic cmp_dut(input int d, input string nm, input logic [7:0] oh,
                           input logic ov, input logic ob, input logic ordy);
        logic exp_v;
        exp_v = (age[d] >= 1) && (age[d] <= hc[d]);
        chk({nm, " onehot"}, oh, exp_v ? mword[d] : 8'h00);
        chk({nm, " out_valid"}, ov, exp_v);
        chk({nm, " busy"}, ob, age[d] != 0);
        chk({nm, " in_ready"}, ordy, age[d] == 0);
        chk({nm, " popcount<=1"}, ($countones(oh) > 1), 0);
        if (oh != 8'h00) begin
            chk({nm, " roundtrip"}, prio_enc(oh), midx[d]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut(0, "A", a_onehot, a_valid, a_busy, a_ready);
            cmp_dut(1, "B", b_onehot, b_valid, b_busy, b_ready);
        end
    end

    // Starts at a falling edge; ends at the falling edge of the idle cycle.
    task automatic do_txn(input logic [2:0] idx, input logic en, input logic [7:0] exp_w);
        in_valid = 1'b1;
        in_idx   = idx;
        in_en    = en;
        @(posedge clk);
        for (int i = 0; i < H_A; i++) begin
            @(negedge clk);
            chk("txn word", a_onehot, exp_w);
            chk("txn valid", a_valid, 1);
        end
        @(negedge clk);
        chk("gap word", a_onehot, 8'h00);
        chk("gap valid", a_valid, 0);
        chk("gap busy", a_busy, 1);
        chk("gap ready", a_ready, 0);
        @(negedge clk);
        chk("idle ready", a_ready, 1);
        chk("idle busy", a_busy, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst onehot", a_onehot, 8'h00);
        chk("rst ready", a_ready, 1);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle onehot", a_onehot, 8'h00);
            chk("idle valid", a_valid, 0);
            chk("idle busy", a_busy, 0);
            chk("idle ready", a_ready, 1);
        end

        do_txn(3'd5, 1'b1, 8'h20);
        in_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            logic [7:0] w_exp;
            w_exp = 8'(1 << k);
            do_txn(3'(k), 1'b1, w_exp);
        end
        in_valid = 1'b0;

        do_txn(3'd3, 1'b0, 8'h00);
        in_valid = 1'b0;

        // Asynchronous reset in the second HOLD cycle.
        in_valid = 1'b1;
        in_idx   = 3'd6;
        in_en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst word", a_onehot, 8'h40);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst onehot", a_onehot, 8'h00);
        chk("async rst ready", a_ready, 1);
        chk("async rst valid", a_valid, 0);
        chk("async rst busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(3'd2, 1'b1, 8'h04);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Corner instance: single-cycle strobe, period 2 with in_valid held.
        in_valid = 1'b1;
        in_idx   = 3'd7;
        in_en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("B strobe word", b_onehot, 8'h80);
            chk("B strobe valid", b_valid, 1);
            @(posedge clk);
            @(negedge clk);
            chk("B after word", b_onehot, 8'h00);
            chk("B after ready", b_ready, 1);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end
            in_valid = ($urandom_range(0, 2) != 0);
            in_idx   = 3'($urandom_range(0, 7));
            in_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
